// File: rtl/store_narrow_pkg.sv
// store_pkg: shared types, lane count and lane-merge helper for the store_narrow write path.
package store_pkg;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL} size_t;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
    localparam int LANES = 4;
    function automatic logic [31:0] merge_lanes(input logic [31:0] nd, input logic [31:0] od, input logic [LANES-1:0] be);
        for (int i = 0; i < LANES; i++) merge_lanes[8*i+:8] = be[i] ? nd[8*i+:8] : od[8*i+:8];
    endfunction
endpackage

// File: rtl/store_narrow_byte_lane.sv
// byte_lane_gen: maps a store's size and low address bits to byte enables, replicated lane data and a misalignment flag.
module byte_lane_gen
    import store_pkg::*;
(
    input  logic [1:0]       addr,
    input  logic [1:0]       size,
    input  logic [31:0]      data,
    output logic [LANES-1:0] be,
    output logic [31:0]      lane_data,
    output logic             misaligned
);
    always_comb begin
        misaligned = size == SZ_ILL || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'd0);
        be = size == SZ_BYTE ? 4'b0001 << addr : size == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        lane_data = size == SZ_BYTE ? {4{data[7:0]}} : size == SZ_HALF ? {2{data[15:0]}} : data;
    end
endmodule

// File: rtl/store_narrow.sv
// store_narrow: narrows SB/SH/SW register data into a word-aligned byte-enabled memory write.
// STORE_NARROW_RMW_EN adds a read-modify-write pass for memories lacking byte enables.
module store_narrow
    import store_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);
    state_t state;
    logic [LANES-1:0] lane_be;
    logic [31:0] lane_data;
    logic lane_mis;
    byte_lane_gen u_lanes (
        .addr(req_addr[1:0]),
        .size(req_size),
        .data(req_data),
        .be(lane_be),
        .lane_data(lane_data),
        .misaligned(lane_mis)
    );
    assign req_ready = state == S_IDLE;
    assign busy = !req_ready;
`ifdef STORE_NARROW_RMW_EN
    logic [LANES-1:0] be_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign mem_re = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            misalign  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_we    <= 1'b0;
`ifdef STORE_NARROW_RMW_EN
            mem_re    <= 1'b0;
            be_q      <= '0;
`endif
        end else begin
            misalign <= 1'b0;
            case (state)
                S_IDLE: if (req_valid) begin
                    if (lane_mis) misalign <= 1'b1;
                    else begin
                        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= lane_data;
`ifdef STORE_NARROW_RMW_EN
                        be_q <= lane_be;
                        if (&lane_be) begin
                            mem_be <= lane_be;
                            mem_we <= 1'b1;
                            state  <= S_WRITE;
                        end else begin
                            mem_be <= '0;
                            mem_re <= 1'b1;
                            state  <= S_READ;
                        end
`else
                        mem_be <= lane_be;
                        mem_we <= 1'b1;
                        state  <= S_WRITE;
`endif
                    end
                end
`ifdef STORE_NARROW_RMW_EN
                // merged word goes out as a full-width write
                S_READ: if (mem_ack) begin
                    mem_wdata <= merge_lanes(mem_wdata, mem_rdata, be_q);
                    mem_be    <= '1;
                    mem_re    <= 1'b0;
                    mem_we    <= 1'b1;
                    state     <= S_WRITE;
                end
`endif
                S_WRITE: if (mem_ack) begin
                    mem_we <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_narrow.sv
// tb_store_narrow: directed stores with a scoreboard of expected memory writes and misalign pulses.
module tb_store_narrow;
    typedef struct {
        bit          mis;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        misalign;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    ev_t exp_q[$];
    ev_t cur;
    bit  we_q = 1'b0;
    int  run_len = 0;
    int  last_len = 0;

    store_narrow dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size), .misalign(misalign),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_q.push_back('{mis: 1'b0, addr: a, data: d, be: be});
    endtask

    task automatic expect_m();
        exp_q.push_back('{mis: 1'b1, addr: '0, data: '0, be: '0});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // returns one tick into the cycle after acceptance
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        step();
        req_addr = a;
        req_data = d;
        req_size = s;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic ack_after(input int n);
        repeat (n) step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            we_q = 1'b0;
            run_len = 0;
        end else begin
            if (mem_we || mem_re) check("we_re_overlap", {31'd0, mem_we && mem_re}, 32'd0);
            if (mem_we && !we_q) begin
                if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                else begin
                    cur = exp_q.pop_front();
                    check("write_kind", {31'd0, cur.mis}, 32'd0);
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_wdata", mem_wdata, cur.data);
                    check("mem_be", {28'd0, mem_be}, {28'd0, cur.be});
                end
            end else if (mem_we) begin
                check("hold_addr", mem_addr, cur.addr);
                check("hold_wdata", mem_wdata, cur.data);
                check("hold_be", {28'd0, mem_be}, {28'd0, cur.be});
            end
            if (misalign) begin
                if (exp_q.size() == 0) check("unexpected_misalign", 32'd1, 32'd0);
                else begin
                    cur = exp_q.pop_front();
                    check("misalign_kind", {31'd0, cur.mis}, 32'd1);
                end
            end
            if (mem_we) run_len++;
            else if (we_q) begin
                last_len = run_len;
                run_len = 0;
            end
            we_q = mem_we;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_we_re_mis", {29'd0, mem_we, mem_re, misalign}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_be", {28'd0, mem_be}, 32'd0);
        step();
        rst_n = 1'b1;
`ifndef STORE_NARROW_RMW_EN
        expect_w(32'h1000, 32'hEFEFEFEF, 4'b1000);
        send(32'h1003, 32'hDEADBEEF, 2'd0);
        check("sb_ready_c1", {31'd0, req_ready}, 32'd0);
        check("sb_we_c1", {31'd0, mem_we}, 32'd1);
        ack_after(0);
        check("sb_ready_c2", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        #1;
        check("sb_we_len", last_len, 32'd1);
        expect_w(32'h2000, 32'h56785678, 4'b1100);
        send(32'h2002, 32'h12345678, 2'd1);
        ack_after(3);
        check("sh_ready_after", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        #1;
        check("sh_we_len", last_len, 32'd4);
        expect_w(32'h0, 32'hA5A5A5A5, 4'b0001);
        send(32'h0, 32'h000000A5, 2'd0);
        ack_after(1);
        expect_w(32'h10, 32'hBEEFBEEF, 4'b0011);
        send(32'h10, 32'hFFFFBEEF, 2'd1);
        ack_after(0);
        expect_m();
        send(32'h2001, 32'h1234, 2'd1);
        check("sh_mis_ready", {31'd0, req_ready}, 32'd1);
`else
        mem_rdata = 32'h11223344;
        expect_w(32'h4000, 32'h1122AA44, 4'b1111);
        send(32'h4001, 32'h000000AA, 2'd0);
        check("rmw_re_c1", {30'd0, mem_re, mem_we}, 32'd2);
        ack_after(0);
        check("rmw_we_c2", {30'd0, mem_re, mem_we}, 32'd1);
        ack_after(0);
        check("rmw_ready_c3", {31'd0, req_ready}, 32'd1);
`endif
        expect_m();
        send(32'h3001, 32'hFFFFFFFF, 2'd2);
        check("sw_mis_ready", {31'd0, req_ready}, 32'd1);
        check("sw_mis_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        check("sw_mis_no_we", {31'd0, mem_we}, 32'd0);
        expect_m();
        send(32'h3000, 32'hFFFFFFFF, 2'd3);
        check("ill_ready", {31'd0, req_ready}, 32'd1);
        step();
        step();
        check("ill_no_we", {31'd0, mem_we}, 32'd0);
        expect_w(32'h5000, 32'hCAFEF00D, 4'b1111);
        send(32'h5000, 32'hCAFEF00D, 2'd2);
        check("rst_mid_we", {31'd0, mem_we}, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_we_low", {31'd0, mem_we}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_we", {30'd0, mem_we, busy}, 32'd0);
        expect_w(32'h6000, 32'h11111111, 4'b1111);
        expect_w(32'h6004, 32'h22222222, 4'b1111);
        req_addr = 32'h6000;
        req_data = 32'h11111111;
        req_size = 2'd2;
        req_valid = 1'b1;
        step();
        req_addr = 32'h6004;
        req_data = 32'h22222222;
        check("b2b_ready_c1", {31'd0, req_ready}, 32'd0);
        ack_after(0);
        check("b2b_ready_c2", {31'd0, req_ready}, 32'd1);
        check("b2b_we_c2", {31'd0, mem_we}, 32'd0);
        step();
        req_valid = 1'b0;
        check("b2b_ready_c3", {31'd0, req_ready}, 32'd0);
        check("b2b_we_c3", {31'd0, mem_we}, 32'd1);
        ack_after(0);
        check("b2b_ready_end", {31'd0, req_ready}, 32'd1);
        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
